// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- bundle of the run-enable input and the raster timing
// outputs of vga_timing_gen.
//   en          : run enable (low freezes the raster)
//   pclk_en     : one-clk pulse per pixel advance
//   h_cnt/v_cnt : current pixel column / line
//   hsync/vsync : active-low sync pulses
//   valid       : high inside the visible area
//   frame_tick  : one-clk pulse at frame start
// The master modport is the timing generator; the slave modport is a consumer
// (pixel pipeline, address generators) that also owns the enable.
interface vga_timing_gen_if;
    logic       en;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       frame_tick;

    modport master (
        input  en,
        output pclk_en, h_cnt, v_cnt, hsync, vsync, valid, frame_tick
    );

    modport slave (
        output en,
        input  pclk_en, h_cnt, v_cnt, hsync, vsync, valid, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
// Divides clk by DIV to obtain the pixel rate, walks a pixel column counter
// over H_TOTAL pixels and a line counter over V_TOTAL lines, and decodes
// sync/visible flags from the live counter values.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset
//   vga   : vga_timing_gen_if.master (en in; pclk_en, h_cnt, v_cnt, hsync,
//           vsync, valid, frame_tick out)
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_cnt_q, div_cnt_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_tick_q, frame_tick_d;

    logic       pclk_en;
    logic       h_wrap;
    logic       frame_wrap;

    // Next-state logic for the divider, raster counters and frame tick.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        div_cnt_d    = div_cnt_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = frame_tick_q;

        pclk_en    = vga.en && (div_cnt_q == DIV_LAST);
        h_wrap     = pclk_en && (h_cnt_q == H_LAST);
        frame_wrap = h_wrap && (v_cnt_q == V_LAST);

        if (vga.en) begin
            div_cnt_d = pclk_en ? 4'd0 : div_cnt_q + 4'd1;
        end

        if (pclk_en) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        end

        if (h_wrap) begin
            v_cnt_d = frame_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end

        // The tick is captured on the wrap edge. If en drops in the very next
        // cycle the tick is parked (and masked at the output) until en
        // returns, so it is neither lost nor emitted while frozen.
        if (vga.en) begin
            frame_tick_d = frame_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= 4'd0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, independent of statement order.
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Decodes read the registered counters directly, so sync/valid change in
    // the same cycle as the counters they describe.
    assign vga.pclk_en    = pclk_en;
    assign vga.h_cnt      = h_cnt_q;
    assign vga.v_cnt      = v_cnt_q;
    assign vga.hsync      = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vga.vsync      = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign vga.valid      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign vga.frame_tick = frame_tick_q && vga.en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
// Two instances share one clock: dut_a uses the default 640x480 timing,
// dut_b uses DIV=2 with H 8/2/2/2 and V 4/1/1/1 so whole frames are short.
// The reference model counts enabled clk edges since reset and derives every
// output from that count with plain division/modulo arithmetic.
module tb_vga_timing_gen;

    localparam int A_DIV = 4;
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;

    localparam int B_DIV = 2;
    localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_FRAME = B_DIV * (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    logic   clk = 1'b0;
    logic   rst_a, rst_b;
    int     vectors = 0;
    int     miscompares = 0;
    longint na = 0;
    longint nb = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (ifa)
    );

    vga_timing_gen #(
        .DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (ifb)
    );

    // Packed observation: {pclk_en, h_cnt, v_cnt, hsync, vsync, valid, frame_tick}
    logic [24:0] obs_a, obs_b;
    assign obs_a = {ifa.pclk_en, ifa.h_cnt, ifa.v_cnt, ifa.hsync, ifa.vsync, ifa.valid, ifa.frame_tick};
    assign obs_b = {ifb.pclk_en, ifb.h_cnt, ifb.v_cnt, ifb.hsync, ifb.vsync, ifb.valid, ifb.frame_tick};

    // n = number of enabled clk edges since reset release.
    function automatic logic [24:0] model(longint n, logic en, int dv,
                                          int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
        int     ht;
        int     vt;
        longint pix;
        int     h;
        int     v;
        logic   pclk, hsn, vsn, vld, ft;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        pix  = n / dv;
        h    = int'(pix % ht);
        v    = int'((pix / ht) % vt);
        pclk = en && ((n % dv) == dv - 1);
        hsn  = !((h >= ha + hf) && (h < ha + hf + hs));
        vsn  = !((v >= va + vf) && (v < va + vf + vs));
        vld  = (h < ha) && (v < va);
        ft   = en && (n > 0) && ((n % longint'(dv * ht * vt)) == 0);
        return {pclk, 10'(h), 10'(v), hsn, vsn, vld, ft};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_now();
        check("dut_a_model", 32'(obs_a),
              32'(model(na, ifa.en, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB)));
        check("dut_b_model", 32'(obs_b),
              32'(model(nb, ifb.en, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB)));
    endtask

    // Advance one clk, update the models with the en sampled at the edge,
    // then compare #1 after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_a && ifa.en) na++;
        if (rst_b && ifb.en) nb++;
        #1;
        check_now();
    endtask

    task automatic run_to_a(string tag, int h, logic need_pclk);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            if (ifa.h_cnt == 10'(h) && (!need_pclk || ifa.pclk_en)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic run_to_b_pos(string tag, longint pos);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ((nb % B_FRAME) == pos) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int ticks;
        int last_tick;
        int gap_bad;
        int first_tick;
        bit found;

        rst_a  = 1'b0;
        rst_b  = 1'b0;
        ifa.en = 1'b1;
        ifb.en = 1'b1;

        // Reset state: (0,0) is visible, syncs inactive, no pulses.
        repeat (3) step();
        check("reset_state_a", 32'(obs_a), 32'({1'b0, 10'd0, 10'd0, 4'b1110}));

        // Release between edges; first pixel advance on the 4th edge.
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) step();
        check("pclk_en_4th_cycle", 32'(ifa.pclk_en), 32'd1);
        check("h_before_4th_edge", 32'(ifa.h_cnt), 32'd0);
        step();
        check("h_after_4th_edge", 32'(ifa.h_cnt), 32'd1);
        check("v_after_4th_edge", 32'(ifa.v_cnt), 32'd0);

        // Line timing on the default raster.
        run_to_a("reach_h639", 639, 1'b1);
        step();
        check("valid_fall_h640", 32'({ifa.valid, ifa.h_cnt}), 32'({1'b0, 10'd640}));
        run_to_a("reach_h655", 655, 1'b1);
        check("hsync_high_h655", 32'(ifa.hsync), 32'd1);
        step();
        check("hsync_fall_h656", 32'({ifa.hsync, ifa.h_cnt}), 32'({1'b0, 10'd656}));
        run_to_a("reach_h751", 751, 1'b1);
        step();
        check("hsync_rise_h752", 32'({ifa.hsync, ifa.h_cnt}), 32'({1'b1, 10'd752}));
        run_to_a("reach_h799", 799, 1'b1);
        step();
        check("line_wrap", 32'({ifa.h_cnt, ifa.v_cnt}), 32'({10'd0, 10'd1}));

        // Randomised enable on both instances.
        for (int i = 0; i < 600; i++) begin
            ifa.en = ($urandom_range(3) != 0);
            ifb.en = ($urandom_range(3) != 0);
            step();
        end
        ifa.en = 1'b1;
        ifb.en = 1'b1;

        // Asynchronous reset mid-line on dut_a, between clk edges.
        run_to_a("reach_h700", 700, 1'b0);
        #3;
        rst_a = 1'b0;
        na    = 0;
        #1;
        check("async_rst_hv", 32'({ifa.h_cnt, ifa.v_cnt}), 32'd0);
        check("async_rst_sync_tick", 32'({ifa.hsync, ifa.frame_tick, ifa.pclk_en}), 32'b100);
        check_now();
        step();
        step();
        #2;
        rst_a = 1'b1;
        repeat (10) step();

        // dut_b: three frames with en high, one tick every B_FRAME clks.
        run_to_b_pos("b_reach_frame_end", longint'(B_FRAME - 1));
        ticks     = 0;
        last_tick = -1;
        gap_bad   = 0;
        for (int i = 0; i < 3 * B_FRAME; i++) begin
            step();
            if (ifb.frame_tick) begin
                if (last_tick >= 0 && (i - last_tick) != B_FRAME) gap_bad++;
                last_tick = i;
                ticks++;
            end
        end
        check("b_tick_count", 32'(ticks), 32'd3);
        check("b_tick_spacing", 32'(gap_bad), 32'd0);

        // Drop en exactly when the frame wrap would happen; hold 37 clks.
        check("b_pclk_at_last_pixel", 32'({ifb.pclk_en, ifb.h_cnt, ifb.v_cnt}), 32'({1'b1, 10'd13, 10'd6}));
        ifb.en = 1'b0;
        repeat (37) step();
        check("b_hold_frozen", 32'({ifb.h_cnt, ifb.v_cnt, ifb.pclk_en, ifb.frame_tick}),
              32'({10'd13, 10'd6, 2'b00}));
        ifb.en = 1'b1;
        #1;
        check("b_pclk_on_resume", 32'(ifb.pclk_en), 32'd1);
        step();
        check("b_wrap_after_hold", 32'({ifb.h_cnt, ifb.v_cnt, ifb.frame_tick}), 32'({10'd0, 10'd0, 1'b1}));

        for (int i = 0; i < 1500; i++) begin
            ifb.en = ($urandom_range(4) != 0);
            step();
        end
        ifb.en = 1'b1;

        // Mid-frame asynchronous reset on dut_b: frame abandoned, first tick
        // only after one complete frame.
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (ifb.v_cnt == 10'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("b_reach_v3", 32'(found), 32'd1);
        #3;
        rst_b = 1'b0;
        nb    = 0;
        #1;
        check("b_async_rst", 32'({ifb.h_cnt, ifb.v_cnt, ifb.frame_tick}), 32'd0);
        step();
        #2;
        rst_b = 1'b1;
        ticks      = 0;
        first_tick = -1;
        for (int i = 0; i < 2 * B_FRAME + 5; i++) begin
            step();
            if (ifb.frame_tick) begin
                if (first_tick < 0) first_tick = i;
                ticks++;
            end
        end
        check("b_first_tick_after_rst", 32'(first_tick), 32'(B_FRAME - 1));
        check("b_ticks_after_rst", 32'(ticks), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); legal values 2..16.
REQ-002 Parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels; H_TOTAL = their sum, 800 by default.
REQ-003 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines; V_TOTAL = their sum, 525 by default.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  run enable; low freezes all counters.
REQ-008 pclk_en  output  1  one-clk pulse marking each pixel advance.
REQ-009 h_cnt  output  10  current pixel column, 0..H_TOTAL-1; drives the address generators.
REQ-010 v_cnt  output  10  current line, 0..V_TOTAL-1.
REQ-011 hsync  output  1  horizontal sync, active low.
REQ-012 vsync  output  1  vertical sync, active low.
REQ-013 valid  output  1  high inside the visible area.
REQ-014 frame_tick  output  1  one-clk pulse at frame start; used for scroll and game updates.

Function
REQ-015 div_cnt SHALL count 0..DIV-1 and wrap to 0 on every clk edge while en=1.
REQ-016 pclk_en SHALL be high exactly when div_cnt == DIV-1 and en=1; the result is one pulse per DIV clks.
REQ-017 On an edge where pclk_en=1, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-018 v_cnt SHALL increment only on the edge where h_cnt wraps; at V_TOTAL-1 with h_cnt wrapping, v_cnt SHALL wrap to 0.
REQ-019 h_cnt and v_cnt SHALL be registers and SHALL hold their value between pclk_en pulses.
REQ-020 hsync SHALL be 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, which is 656..751 by default.
REQ-021 vsync SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, which is 490..491 by default.
REQ-022 valid SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-023 hsync, vsync and valid SHALL be decoded from the current h_cnt and v_cnt values, with zero latency relative to the counters, so all outputs stay mutually consistent in every clk cycle.
REQ-024 frame_tick SHALL be registered and high for exactly one clk cycle: the first cycle after the counters wrap (V_TOTAL-1, H_TOTAL-1) -> (0,0).
REQ-025 frame_tick SHALL NOT fire on reset release; the first frame_tick comes after one full frame.
REQ-026 en=0 SHALL hold div_cnt, h_cnt and v_cnt; pclk_en and frame_tick SHALL be 0 while en=0.
REQ-027 When en returns to 1, counting SHALL resume from the held div_cnt value, with no skipped or repeated pixel.
REQ-028 en deasserted in the same cycle a wrap would occur SHALL suppress the wrap and any frame_tick until the next enabled pclk_en.
REQ-029 Counter arithmetic SHALL be 10-bit unsigned; no counter SHALL ever exceed its TOTAL-1.

Reset
REQ-030 rst=0 SHALL immediately, without waiting for a clk edge, set div_cnt=0, h_cnt=0, v_cnt=0, pclk_en=0 and frame_tick=0.
REQ-031 During reset the decoded outputs SHALL be hsync=1, vsync=1 and valid=1, because (0,0) is a visible pixel.
REQ-032 After reset release, the first pclk_en SHALL occur DIV clk edges later: on the 4th edge by default.
REQ-033 Reset asserted mid-frame SHALL abandon the frame, with no frame_tick generated.

Verification
REQ-034 Reset release with en=1, 4 clk edges: pclk_en high in the 4th cycle, after which h_cnt=1 and v_cnt=0.
REQ-035 Line timing check: hsync falls as h_cnt goes 655->656 and rises at 752; valid falls at h_cnt=640; after 800 pixels h_cnt=0 and v_cnt=1.
REQ-036 Run a full frame of 800*525*4 = 1,680,000 clks: vsync low for v_cnt 490..491 (1600 pixels total); exactly one frame_tick, aligned to the (0,0) wrap.
REQ-037 Hold en=0 for 37 clks at h_cnt=799, v_cnt=524, then release: counters frozen and no pulses during the hold; the wrap to (0,0) with frame_tick occurs on the next enabled pclk_en.
REQ-038 Assert rst=0 asynchronously between clk edges at h_cnt=700, v_cnt=300: outputs go to h=0, v=0, hsync=1 and frame_tick=0 before the next edge.
REQ-039 Repeat with DIV=2 and a reduced timing of H 8/2/2/2, V 4/1/1/1: H_TOTAL=14, V_TOTAL=7, and frame_tick every 196 clks.
